icache_sa: RTL

- Parametrised set-associative instruction cache between the PC generator and the memory controller; successor to the direct-mapped single-way fetch cache.
- A hit returns the instruction combinationally in the request cycle.
- A miss runs a refill FSM against the memory port, fills the chosen way, forwards the word on the fill cycle, and stalls the front end until then.
- Adds a configurable set count, 1 or 2 ways with LRU replacement, flush/abort of in-flight misses, and whole-cache invalidate.

---
 rtl/icache_sa_pkg.sv | 25 ++
 rtl/icache_sa_way.sv | 60 ++++++
 rtl/icache_sa.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/icache_sa_pkg.sv
// Shared constants for the set-associative instruction cache: default widths,
// boolean helpers, the refill FSM state encodings and a small way helper.
// The optional hit/miss counters are enabled with the ICACHE_STATS_EN macro
// (see icache_sa.sv).
package icache_sa_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_INST_W = 32;

  localparam logic [DEF_INST_W-1:0] ZERO_WORD = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Refill FSM encodings, kept as plain constants for compatibility with the
  // older fetch-path code that compares against them directly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // In a two-way set, "the other way" is the one to replace next.
  function automatic logic other_way(input logic way);
    return ~way;
  endfunction

endpackage

// File: rtl/icache_sa_way.sv
// One way of the instruction cache: per-set data, tag and valid bit.
// Lookup is purely combinational on rd_idx_i/rd_tag_i; the write port and the
// whole-way invalidate take effect on the next clock edge.
module icache_way
  import icache_sa_pkg::*;
#(
  parameter int SETS   = 128,
  parameter int IDX_W  = 7,
  parameter int TAG_W  = 23,
  parameter int INST_W = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [TAG_W-1:0]  rd_tag_i,
  output logic              hit_o,
  output logic              valid_o,
  output logic [INST_W-1:0] data_o,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [INST_W-1:0] wr_data_i,
  input  logic              inv_i
);

  logic [INST_W-1:0] data_q [SETS];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q;

  // Refill write of the data and tag arrays.
  // NOTE: the data/tag arrays carry no reset; valid_q alone decides whether an
  // entry can hit, so these stay plain RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
      tag_q[wr_idx_i]  <= wr_tag_i;
    end
  end

  // Valid bits: reset, whole-way invalidate, then the refill's own entry.
  // NOTE: non-blocking assignments in one block resolve last-wins, which is how
  // a fill coinciding with an invalidate keeps its entry valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      if (inv_i) begin
        valid_q <= '0;
      end
      if (wr_en_i) begin
        valid_q[wr_idx_i] <= TRUE;
      end
    end
  end

  assign valid_o = valid_q[rd_idx_i];
  assign hit_o   = valid_o && (tag_q[rd_idx_i] == rd_tag_i);
  assign data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache (1 or 2 ways, LRU replacement).
// Hits answer combinationally in the request cycle; a miss runs a refill FSM
// (IDLE -> REQ -> IDLE) against the memory port and forwards the word in the
// fill cycle. A flush during a refill moves to DRAIN so the returning word is
// still written but never answered. rdy=0 freezes every register and array.
// Optional: define ICACHE_STATS_EN to add hit_cnt/miss_cnt counter outputs.
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SETS   = 128,
  parameter int WAYS   = 2,
  parameter int INST_W = DEF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              inv,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              resp_valid,
  output logic [INST_W-1:0] resp_inst,
  output logic [ADDR_W-1:0] resp_pc,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [INST_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              victim_q, victim_d;

  logic [IDX_W-1:0]  req_idx, fill_idx;
  logic [TAG_W-1:0]  req_tag, fill_tag;

  logic [WAYS-1:0]   way_hit;
  logic [WAYS-1:0]   way_vld;
  logic [INST_W-1:0] way_data [WAYS];

  logic              any_hit;
  logic              hit_way;
  logic              victim_way;
  logic [INST_W-1:0] hit_data;

  logic              live;
  logic              idle;
  logic              busy;
  logic              hit_fire;
  logic              miss_start;
  logic              fill_fire;
  logic              fill_resp;

  assign req_idx  = req_pc[IDX_W+1:2];
  assign req_tag  = req_pc[ADDR_W-1:IDX_W+2];
  assign fill_idx = pc_q[IDX_W+1:2];
  assign fill_tag = pc_q[ADDR_W-1:IDX_W+2];

  // ---------------------------------------------------------------------------
  // Ways
  // ---------------------------------------------------------------------------
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS   (SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .INST_W (INST_W)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_i  (req_idx),
      .rd_tag_i  (req_tag),
      .hit_o     (way_hit[w]),
      .valid_o   (way_vld[w]),
      .data_o    (way_data[w]),
      .wr_en_i   (fill_fire && (victim_q == 1'(w))),
      .wr_idx_i  (fill_idx),
      .wr_tag_i  (fill_tag),
      .wr_data_i (mem_rdata),
      .inv_i     (live && inv)
    );
  end

  assign any_hit = |way_hit;

  // ---------------------------------------------------------------------------
  // Way selection and LRU
  // ---------------------------------------------------------------------------
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru_q;

    // Way 0 wins when both ways match.
    assign hit_way  = way_hit[0] ? 1'b0 : 1'b1;
    assign hit_data = way_hit[0] ? way_data[0] : way_data[1];
    // Fill an invalid way first, otherwise the one the LRU bit names.
    assign victim_way = !way_vld[0] ? 1'b0 :
                        !way_vld[1] ? 1'b1 : lru_q[req_idx];

    // LRU bit per set: cleared by invalidate, then pointed away from the way
    // just used by a hit or a fill.
    always_ff @(posedge clk) begin
      if (rst) begin
        lru_q <= '0;
      end else if (rdy) begin
        if (inv) begin
          lru_q <= '0;
        end
        if (hit_fire) begin
          lru_q[req_idx] <= other_way(hit_way);
        end
        if (fill_fire) begin
          lru_q[fill_idx] <= other_way(victim_q);
        end
      end
    end
  end else begin : g_dm
    // Direct-mapped: everything lives in way 0.
    logic unused_way_vld;
    assign unused_way_vld = ^way_vld;
    assign hit_way        = 1'b0;
    assign hit_data       = way_data[0];
    assign victim_way     = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign live       = rdy && !rst;
  assign idle       = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign hit_fire   = live && idle && req_valid && !flush && any_hit;
  assign miss_start = live && idle && req_valid && !flush && !any_hit;
  assign fill_fire  = live && busy && mem_valid;
  // Only an un-flushed refill answers the front end.
  assign fill_resp  = fill_fire && (state_q == ST_REQ) && !flush;

  // Refill FSM next state and miss capture.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    victim_d = victim_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_start) begin
          state_d  = ST_REQ;
          pc_d     = req_pc;
          victim_d = victim_way;
        end
      end
      ST_REQ: begin
        if (fill_fire) begin
          state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fill_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and miss registers; frozen while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      victim_q <= FALSE;
    end else if (rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      victim_q <= victim_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign resp_valid = hit_fire || fill_resp;
  assign resp_inst  = hit_fire  ? hit_data  :
                      fill_resp ? mem_rdata : '0;
  assign resp_pc    = hit_fire  ? req_pc :
                      fill_resp ? pc_q   : '0;
  assign stall      = miss_start ||
                      (live && (state_q == ST_REQ) && !mem_valid && !flush);
  // mem_req follows the registered state, so it holds while rdy is low and
  // drops the cycle after the fill.
  assign mem_req    = !rst && busy;
  assign mem_addr   = (!rst && busy) ? pc_q : '0;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Free-running hit/miss counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_fire) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (miss_start) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule
